// File: rtl/sisc_pkg.sv
// Shared SISC definitions: result-lane select codes, lane count and lane FSM encoding.
// Used by the writeback demultiplexer and its per-lane holding registers.
package sisc_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_D = 2'd3;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

    function automatic logic [NUM_LANES-1:0] sel_onehot(input logic [1:0] s);
        logic [NUM_LANES-1:0] oh;
        oh    = '0;
        oh[s] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_lane.sv
// One-entry holding register with a valid flag for a single result consumer.
// The lane FSM state is exported so checkers can observe EMPTY/FULL directly.
module demux_lane
    import sisc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill,
    input  logic [WIDTH-1:0] din,
    output logic             ready_o,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    input  logic             ready_i,
    output lane_state_t      state
);

    // Handshake: a word moves to the consumer on any edge where valid && ready_i.
    // ready_o tells the producer side this lane can take a word this edge, which
    // includes a FULL lane that is being drained in the same edge.
    assign valid   = (state == LANE_FULL);
    assign ready_o = (state == LANE_EMPTY) || ready_i;

    // fill is only raised by the top while ready_o is high, so a FULL lane that
    // sees fill is always being drained at the same time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LANE_EMPTY;
            dout  <= '0;
        end else begin
            case (state)
                LANE_EMPTY: begin
                    if (fill) begin
                        state <= LANE_FULL;
                        dout  <= din;
                    end
                end
                LANE_FULL: begin
                    if (fill) begin
                        dout <= din;
                    end else if (ready_i) begin
                        state <= LANE_EMPTY;
                    end
                end
                default: state <= LANE_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/demux32_buf.sv
// 1-to-4 buffered demultiplexer steering writeback words to the RF, PC, MAR and IO lanes.
// Each lane has its own holding register, so a stalled consumer only blocks words sent to it.
module demux32_buf
    import sisc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           sel,
    output logic [WIDTH-1:0]     out_a,
    output logic [WIDTH-1:0]     out_b,
    output logic [WIDTH-1:0]     out_c,
    output logic [WIDTH-1:0]     out_d,
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [CNT_W-1:0]     acc_cnt,
    output logic                 busy
);

    logic [NUM_LANES-1:0] lane_ready;
    logic [NUM_LANES-1:0] lane_fill;
    logic [WIDTH-1:0]     lane_dout  [NUM_LANES];
    lane_state_t          lane_state [NUM_LANES];
    logic [NUM_LANES-1:0] lane_full;
    logic                 accept;

    // Acceptance looks only at the addressed lane: no head-of-line blocking.
    assign in_ready  = !rst && lane_ready[sel];
    assign accept    = in_valid && in_ready;
    assign lane_fill = accept ? sel_onehot(sel) : '0;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        demux_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .fill    (lane_fill[i]),
            .din     (in_data),
            .ready_o (lane_ready[i]),
            .dout    (lane_dout[i]),
            .valid   (out_valid[i]),
            .ready_i (out_ready[i]),
            .state   (lane_state[i])
        );
        assign lane_full[i] = (lane_state[i] == LANE_FULL);
    end

    assign out_a = lane_dout[SEL_A];
    assign out_b = lane_dout[SEL_B];
    assign out_c = lane_dout[SEL_C];
    assign out_d = lane_dout[SEL_D];
    assign busy  = |lane_full;

    // Free-running count of accepted words; wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt <= '0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

endmodule
